// File: rtl/zigbee_pkg.sv
// zigbee_pkg: shared types and defaults for the ZigBee receive deframer.
//   state_t           - deframer FSM states
//   DEF_SFD           - default start-of-frame delimiter (LSB-first on air)
//   DEF_PREAMBLE_BITS - default number of zero bits that arms SFD search
//   MAX_LEN / LEN_W   - largest PHR frame length and the width that holds it
package zigbee_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    PHR,
    PAYLOAD
  } state_t;

  localparam logic [7:0]  DEF_SFD           = 8'hA7;
  localparam int unsigned DEF_PREAMBLE_BITS = 32;
  localparam int unsigned MAX_LEN           = 127;
  localparam int unsigned LEN_W             = $clog2(MAX_LEN + 1);

endpackage

// File: rtl/zigbee_bit_packer.sv
// zigbee_bit_packer: LSB-first 8-bit serial-to-parallel packer.
//   clk_i, reset_i  - clock and synchronous active-high reset
//   clear_i         - empties the shift window and bit counter (beats shift_i)
//   shift_i         - accept bit_i this cycle
//   bit_i           - serial bit; later bits land in higher byte positions
//   data_next_o     - byte as it reads once bit_i is shifted in (combinational)
//   byte_done_o     - high on the shift that supplies the 8th bit of a byte
module zigbee_bit_packer
  import zigbee_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       shift_i,
  input  logic       bit_i,
  output logic [7:0] data_next_o,
  output logic       byte_done_o
);

  // Only the upper seven bits of the window are kept: the oldest bit would be
  // shifted out by the next bit anyway, so data_next_o is rebuilt from these
  // seven plus the incoming bit.
  logic [6:0] window;
  logic [2:0] bit_cnt;

  assign data_next_o = {bit_i, window};
  assign byte_done_o = shift_i && (bit_cnt == 3'd7);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      window  <= '0;
      bit_cnt <= '0;
    end else if (shift_i) begin
      window  <= data_next_o[7:1];
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/zigbee_rx_deframer.sv
// zigbee_rx_deframer: finds preamble + SFD in a recovered bit stream, reads the
// PHR length and emits the payload as bytes.
//   clk_i, reset_i  - clock and synchronous active-high reset
//   data_i          - recovered bit, valid when data_en_i is high
//   data_en_i       - one-cycle bit strobe
//   byte_o          - payload byte (LSB = first received bit)
//   byte_valid_o    - one-cycle strobe qualifying byte_o
//   sof_o / eof_o   - first / last payload byte markers (with byte_valid_o)
//   len_o           - PHR length, held until the next accepted PHR
//   frame_err_o     - one-cycle strobe on a zero length or a timeout abort
//   busy_o          - high whenever the FSM is not hunting for preamble
module zigbee_rx_deframer
  import zigbee_pkg::*;
#(
  parameter int unsigned PREAMBLE_BITS = DEF_PREAMBLE_BITS,
  parameter logic [7:0]  SFD           = DEF_SFD,
  parameter int unsigned TIMEOUT_CYC   = 4096
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             data_i,
  input  logic             data_en_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic [LEN_W-1:0] len_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int unsigned ZW = $clog2(PREAMBLE_BITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ZW-1:0] ZERO_LAST = ZW'(PREAMBLE_BITS - 1);
  localparam logic [ZW-1:0] ZERO_SAT  = ZW'(PREAMBLE_BITS);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [ZW-1:0]    zero_cnt;
  logic [TW-1:0]    idle_cnt;
  logic [LEN_W-1:0] byte_cnt;
  logic             seen_one;

  logic       pk_clear;
  logic       pk_shift;
  logic [7:0] pk_data_next;
  logic       pk_byte_done;

  logic sync_bit;
  logic sfd_take;
  logic timeout_hit;
  logic last_byte;

  zigbee_bit_packer u_packer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (pk_clear),
    .shift_i     (pk_shift),
    .bit_i       (data_i),
    .data_next_o (pk_data_next),
    .byte_done_o (pk_byte_done)
  );

  // In SYNC, zeros ahead of the first 1 are extended preamble and must not
  // start the 8-bit SFD window.
  assign sync_bit    = data_en_i && (seen_one || data_i);
  assign sfd_take    = sync_bit && (pk_data_next == SFD);
  assign timeout_hit = !data_en_i && (idle_cnt == TO_LAST);
  assign last_byte   = ({1'b0, byte_cnt} + 8'd1) == {1'b0, len_o};
  assign busy_o      = (state != HUNT);

  always_comb begin
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    unique case (state)
      HUNT: pk_clear = 1'b1;
      SYNC: begin
        if (data_en_i) begin
          // An SFD match clears the packer so PHR starts on a fresh byte.
          if (!sync_bit || sfd_take) pk_clear = 1'b1;
          else                       pk_shift = 1'b1;
        end
      end
      default: pk_shift = data_en_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= HUNT;
      zero_cnt     <= '0;
      idle_cnt     <= '0;
      byte_cnt     <= '0;
      seen_one     <= 1'b0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
      len_o        <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      byte_valid_o <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
      frame_err_o  <= 1'b0;

      if (state == HUNT || data_en_i) idle_cnt <= '0;
      else                            idle_cnt <= idle_cnt + TW'(1);

      if (state != HUNT && timeout_hit) begin
        frame_err_o <= 1'b1;
        zero_cnt    <= '0;
        state       <= HUNT;
      end else begin
        unique case (state)
          HUNT: begin
            if (data_en_i) begin
              if (data_i) begin
                zero_cnt <= '0;
              end else if (zero_cnt == ZERO_LAST) begin
                zero_cnt <= ZERO_SAT;
                seen_one <= 1'b0;
                state    <= SYNC;
              end else begin
                zero_cnt <= zero_cnt + ZW'(1);
              end
            end
          end

          SYNC: begin
            if (data_en_i && data_i) seen_one <= 1'b1;
            if (sfd_take) begin
              state <= PHR;
            end else if (pk_byte_done) begin
              zero_cnt <= '0;
              state    <= HUNT;
            end
          end

          PHR: begin
            if (pk_byte_done) begin
              if (pk_data_next[6:0] == '0) begin
                frame_err_o <= 1'b1;
                zero_cnt    <= '0;
                state       <= HUNT;
              end else begin
                len_o    <= pk_data_next[6:0];
                byte_cnt <= '0;
                state    <= PAYLOAD;
              end
            end
          end

          PAYLOAD: begin
            if (pk_byte_done) begin
              byte_o       <= pk_data_next;
              byte_valid_o <= 1'b1;
              sof_o        <= (byte_cnt == '0);
              eof_o        <= last_byte;
              byte_cnt     <= byte_cnt + LEN_W'(1);
              if (last_byte) begin
                zero_cnt <= '0;
                state    <= HUNT;
              end
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zigbee_rx_deframer.sv
module tb_zigbee_rx_deframer;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       data_i;
  logic       data_en_i;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       sof_o;
  logic       eof_o;
  logic [6:0] len_o;
  logic       frame_err_o;
  logic       busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [9:0] byte_log[$];
  int n_err_seen = 0;
  int n_busy     = 0;
  int n_stray    = 0;

  zigbee_rx_deframer #(
    .PREAMBLE_BITS (32),
    .SFD           (8'hA7),
    .TIMEOUT_CYC   (4096)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .data_i       (data_i),
    .data_en_i    (data_en_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .sof_o        (sof_o),
    .eof_o        (eof_o),
    .len_o        (len_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Passive log of output pulses, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (byte_valid_o) byte_log.push_back({sof_o, eof_o, byte_o});
    if (frame_err_o) n_err_seen++;
    if (busy_o) n_busy++;
    if ((sof_o || eof_o) && !byte_valid_o) n_stray++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One bit every 4th cycle; returns outputs seen 1 ns after the strobe edge.
  task automatic send_bit(input logic b, output logic v, output logic [7:0] bo,
                          output logic s, output logic e);
    data_i    = b;
    data_en_i = 1'b1;
    @(posedge clk_i); #1;
    data_en_i = 1'b0;
    data_i    = 1'b0;
    v  = byte_valid_o;
    bo = byte_o;
    s  = sof_o;
    e  = eof_o;
    repeat (3) begin @(posedge clk_i); #1; end
  endtask

  task automatic put_bit(input logic b);
    logic v, s, e;
    logic [7:0] bo;
    send_bit(b, v, bo, s, e);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic v, output logic [7:0] bo,
                           output logic s, output logic e);
    for (int i = 0; i < 8; i++) send_bit(b[i], v, bo, s, e);
  endtask

  task automatic put_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) put_bit(1'b0);
  endtask

  task automatic send_header(input int nz, input logic [7:0] phr);
    send_zeros(nz);
    put_byte(8'hA7);
    put_byte(phr);
  endtask

  task automatic test_reset;
    reset_i = 1'b1; data_i = 1'b0; data_en_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({byte_o, byte_valid_o, sof_o, eof_o, len_o, frame_err_o, busy_o} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {byte_o, byte_valid_o, sof_o, eof_o, len_o, frame_err_o, busy_o});
    end
    reset_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic_frame;
    int b0, e0;
    logic v, s, e;
    logic [7:0] bo;
    b0 = byte_log.size(); e0 = n_err_seen;
    send_zeros(31);
    n_cmp++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL preamble_31_busy: got %b want 0", busy_o); end
    put_bit(1'b0);
    n_cmp++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL preamble_32_busy: got %b want 1", busy_o); end
    put_byte(8'hA7);
    put_byte(8'h03);
    send_byte(8'h11, v, bo, s, e);
    n_cmp++;
    if ({v, s, e, bo} !== {3'b110, 8'h11}) begin
      n_fail++; $display("FAIL s1_byte0: got v%b s%b e%b %h want v1 s1 e0 11", v, s, e, bo);
    end
    send_byte(8'h22, v, bo, s, e);
    n_cmp++;
    if ({v, s, e, bo} !== {3'b100, 8'h22}) begin
      n_fail++; $display("FAIL s1_byte1: got v%b s%b e%b %h want v1 s0 e0 22", v, s, e, bo);
    end
    send_byte(8'h33, v, bo, s, e);
    n_cmp++;
    if ({v, s, e, bo} !== {3'b101, 8'h33}) begin
      n_fail++; $display("FAIL s1_byte2: got v%b s%b e%b %h want v1 s0 e1 33", v, s, e, bo);
    end
    n_cmp++;
    if (byte_log.size() - b0 !== 3) begin
      n_fail++; $display("FAIL s1_pulse_count: got %0d want 3", byte_log.size() - b0);
    end
    n_cmp++;
    if ({len_o, busy_o} !== {7'd3, 1'b0}) begin
      n_fail++; $display("FAIL s1_len_busy: got len %0d busy %b want len 3 busy 0", len_o, busy_o);
    end
    n_cmp++;
    if (n_err_seen - e0 !== 0) begin
      n_fail++; $display("FAIL s1_no_err: got %0d errors want 0", n_err_seen - e0);
    end
  endtask

  task automatic test_short_preamble;
    int b0, e0, k0;
    b0 = byte_log.size(); e0 = n_err_seen; k0 = n_busy;
    send_zeros(31);
    put_byte(8'hA7);
    put_byte(8'h03);
    put_bit(1'b1);
    n_cmp++;
    if (n_busy - k0 !== 0) begin
      n_fail++; $display("FAIL s2_busy_cycles: got %0d want 0", n_busy - k0);
    end
    n_cmp++;
    if ({byte_log.size() - b0, n_err_seen - e0} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL s2_no_outputs: got bytes %0d errs %0d want 0 0",
                         byte_log.size() - b0, n_err_seen - e0);
    end
  endtask

  task automatic test_no_sfd;
    int b0, e0;
    logic v, s, e;
    logic [7:0] bo;
    b0 = byte_log.size(); e0 = n_err_seen;
    send_zeros(32);
    put_bit(1'b1);
    for (int i = 0; i < 6; i++) put_bit(1'b0);
    n_cmp++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL s3_sync_7bits_busy: got %b want 1", busy_o); end
    put_bit(1'b0);
    n_cmp++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL s3_giveup_busy: got %b want 0", busy_o); end
    n_cmp++;
    if ({byte_log.size() - b0, n_err_seen - e0} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL s3_silent: got bytes %0d errs %0d want 0 0",
                         byte_log.size() - b0, n_err_seen - e0);
    end
    send_header(32, 8'h02);
    send_byte(8'hC3, v, bo, s, e);
    n_cmp++;
    if ({v, s, e, bo} !== {3'b110, 8'hC3}) begin
      n_fail++; $display("FAIL s3_byte0: got v%b s%b e%b %h want v1 s1 e0 c3", v, s, e, bo);
    end
    send_byte(8'h3C, v, bo, s, e);
    n_cmp++;
    if ({v, s, e, bo} !== {3'b101, 8'h3C}) begin
      n_fail++; $display("FAIL s3_byte1: got v%b s%b e%b %h want v1 s0 e1 3c", v, s, e, bo);
    end
    n_cmp++;
    if (len_o !== 7'd2) begin n_fail++; $display("FAIL s3_len: got %0d want 2", len_o); end
  endtask

  task automatic test_zero_len;
    int b0, e0;
    b0 = byte_log.size(); e0 = n_err_seen;
    send_header(32, 8'h00);
    n_cmp++;
    if (n_err_seen - e0 !== 1) begin
      n_fail++; $display("FAIL s4_err_pulses: got %0d want 1", n_err_seen - e0);
    end
    n_cmp++;
    if ({byte_log.size() - b0, busy_o, len_o} !== {32'd0, 1'b0, 7'd2}) begin
      n_fail++; $display("FAIL s4_state: got bytes %0d busy %b len %0d want 0 0 2",
                         byte_log.size() - b0, busy_o, len_o);
    end
  endtask

  task automatic test_phr_bit7;
    logic v, s, e;
    logic [7:0] bo;
    send_header(32, 8'h81);
    send_byte(8'h0F, v, bo, s, e);
    n_cmp++;
    if ({v, s, e, bo, len_o} !== {3'b111, 8'h0F, 7'd1}) begin
      n_fail++; $display("FAIL phr_bit7: got v%b s%b e%b %h len %0d want v1 s1 e1 0f len 1",
                         v, s, e, bo, len_o);
    end
  endtask

  task automatic test_timeout;
    int b0, e0;
    logic v, s, e;
    logic [7:0] bo;
    b0 = byte_log.size(); e0 = n_err_seen;
    send_header(32, 8'h05);
    send_byte(8'hA1, v, bo, s, e);
    send_byte(8'hB2, v, bo, s, e);
    repeat (4092) begin @(posedge clk_i); #1; end
    n_cmp++;
    if ({frame_err_o, busy_o} !== 2'b01) begin
      n_fail++; $display("FAIL s5_before_timeout: got err %b busy %b want 0 1", frame_err_o, busy_o);
    end
    @(posedge clk_i); #1;
    n_cmp++;
    if ({frame_err_o, busy_o} !== 2'b10) begin
      n_fail++; $display("FAIL s5_at_timeout: got err %b busy %b want 1 0", frame_err_o, busy_o);
    end
    @(posedge clk_i); #1;
    n_cmp++;
    if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL s5_err_width: got %b want 0", frame_err_o); end
    n_cmp++;
    if (byte_log.size() - b0 !== 2) begin
      n_fail++; $display("FAIL s5_bytes: got %0d want 2", byte_log.size() - b0);
    end
    n_cmp++;
    if (byte_log[b0 + 1] !== {2'b00, 8'hB2}) begin
      n_fail++; $display("FAIL s5_last_no_eof: got %h want 0b2", byte_log[b0 + 1]);
    end
    n_cmp++;
    if (n_err_seen - e0 !== 1) begin
      n_fail++; $display("FAIL s5_err_count: got %0d want 1", n_err_seen - e0);
    end
  endtask

  task automatic test_timeout_race;
    int e0;
    logic v, s, e;
    logic [7:0] bo;
    e0 = n_err_seen;
    send_header(32, 8'h01);
    repeat (4092) begin @(posedge clk_i); #1; end
    send_byte(8'h96, v, bo, s, e);
    n_cmp++;
    if ({v, s, e, bo} !== {3'b111, 8'h96}) begin
      n_fail++; $display("FAIL race_byte: got v%b s%b e%b %h want v1 s1 e1 96", v, s, e, bo);
    end
    n_cmp++;
    if (n_err_seen - e0 !== 0) begin
      n_fail++; $display("FAIL race_no_err: got %0d want 0", n_err_seen - e0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int b0, e0;
    logic v, s, e;
    logic [7:0] bo;
    send_header(32, 8'h04);
    put_byte(8'h77);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    e0 = n_err_seen;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    n_cmp++;
    if ({byte_o, byte_valid_o, sof_o, eof_o, len_o, frame_err_o, busy_o} !== 20'h0) begin
      n_fail++;
      $display("FAIL s6_reset_outputs: got %h want 0",
               {byte_o, byte_valid_o, sof_o, eof_o, len_o, frame_err_o, busy_o});
    end
    reset_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    n_cmp++;
    if (n_err_seen - e0 !== 0) begin
      n_fail++; $display("FAIL s6_no_err: got %0d want 0", n_err_seen - e0);
    end
    b0 = byte_log.size();
    send_header(32, 8'h01);
    send_byte(8'h5A, v, bo, s, e);
    n_cmp++;
    if ({v, s, e, bo, len_o} !== {3'b111, 8'h5A, 7'd1}) begin
      n_fail++; $display("FAIL s6_after_reset: got v%b s%b e%b %h len %0d want v1 s1 e1 5a len 1",
                         v, s, e, bo, len_o);
    end
    n_cmp++;
    if (byte_log.size() - b0 !== 1) begin
      n_fail++; $display("FAIL s6_byte_count: got %0d want 1", byte_log.size() - b0);
    end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_short_preamble;
    test_no_sfd;
    test_zero_len;
    test_phr_bit7;
    test_timeout;
    test_timeout_race;
    test_reset_mid_frame;
    n_cmp++;
    if (n_stray !== 0) begin
      n_fail++; $display("FAIL stray_sof_eof: got %0d want 0", n_stray);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/zigbee_rx_deframer.md
ZIGBEE_RX_DEFRAMER -- requirements
Module: zigbee_rx_deframer

Interface
REQ-001 The block SHALL have parameter PREAMBLE_BITS, default 32, the minimum number of consecutive 0 bits that arms SFD search.
REQ-002 The block SHALL have parameter SFD, default 8'hA7, the start-of-frame delimiter, compared LSB-first.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 4096, the clk cycles without data_en_i that abort a frame.
REQ-004 clk_i  in  1  sole clock; all logic on the rising edge.
REQ-005 reset_i  in  1  reset, synchronous and active-high.
REQ-006 data_i  in  1  recovered bit from the CDR stage, qualified by data_en_i.
REQ-007 data_en_i  in  1  one-cycle strobe marking a valid data_i.
REQ-008 byte_o  out  8  payload byte, LSB = first received bit.
REQ-009 byte_valid_o  out  1  one-cycle strobe qualifying byte_o.
REQ-010 sof_o  out  1  asserted with byte_valid_o on the first payload byte.
REQ-011 eof_o  out  1  asserted with byte_valid_o on the last payload byte.
REQ-012 len_o  out  7  PHR frame length, held from PHR acceptance until the next PHR acceptance.
REQ-013 frame_err_o  out  1  one-cycle strobe on frame abort.
REQ-014 busy_o  out  1  high whenever state is not HUNT.

Function
REQ-015 The block SHALL act only on cycles with data_en_i=1, except for the timeout counter and reset.
REQ-016 The FSM SHALL have states HUNT, SYNC, PHR and PAYLOAD.
REQ-017 HUNT: zero_cnt (saturating at PREAMBLE_BITS) increments on each 0 bit and clears on each 1 bit; on reaching PREAMBLE_BITS the FSM SHALL go to SYNC with the shift register cleared.
REQ-018 SYNC: each bit right-shifts into an 8-bit register at bit 7; further 0 bits before the first 1 SHALL keep the FSM in SYNC (extended preamble).
REQ-019 SYNC: when the register equals SFD, the FSM SHALL go to PHR; if 8 bits have been received since the first 1 bit without a match, the FSM SHALL go to HUNT silently, with zero_cnt cleared.
REQ-020 PHR: after 8 bits, LSB-first, len = bits[6:0] and bit 7 is ignored; if len=0 the block SHALL pulse frame_err_o and go to HUNT, otherwise it SHALL latch len_o and go to PAYLOAD.
REQ-021 PAYLOAD: bits SHALL assemble LSB-first; byte_valid_o SHALL pulse the cycle after the data_en_i cycle carrying the 8th bit (latency 1), with byte_o stable during that pulse.
REQ-022 PAYLOAD: a byte counter SHALL track bytes; after byte len is emitted (eof_o=1), the FSM SHALL return to HUNT.
REQ-023 A one-byte frame SHALL assert sof_o and eof_o together.
REQ-024 The timeout counter SHALL clear on every data_en_i and when the FSM is in HUNT.
REQ-025 In SYNC, PHR or PAYLOAD, reaching TIMEOUT_CYC SHALL pulse frame_err_o, discard the partial byte, and go to HUNT; any emitted bytes stand and eof_o is not generated.
REQ-026 If timeout and a data_en_i occur in the same cycle, data_en_i SHALL win and the counter SHALL clear.
REQ-027 A frame SHALL NOT be re-armed until PREAMBLE_BITS fresh zeros are seen in HUNT after returning.
REQ-028 All outputs SHALL be registered, except busy_o, which is decoded from the state register.

Reset
REQ-029 When reset_i=1 at a clock edge, the block SHALL enter HUNT and clear all counters and shift registers.
REQ-030 During reset, byte_o=0, byte_valid_o=0, sof_o=0, eof_o=0, len_o=0, frame_err_o=0 and busy_o=0.
REQ-031 Reset mid-frame SHALL abort without a frame_err_o pulse.

Structure
REQ-032 Package zigbee_pkg SHALL hold the state enum (HUNT, SYNC, PHR, PAYLOAD), the default SFD (8'hA7), the default PREAMBLE_BITS (32) and MAX_LEN (127).
REQ-033 One sub-module, zigbee_bit_packer, SHALL provide the LSB-first 8-bit shift register plus a 3-bit counter with a byte-done strobe, and SHALL be reused by SYNC, PHR and PAYLOAD.
REQ-034 Target size: 150-300 lines of RTL.

Verification
REQ-035 Scenario 1: 32 zeros, SFD A7, PHR 03, payload 11 22 33 (data_en_i every 4th cycle) -> three byte_valid_o pulses 11/22/33 with sof_o on 11 and eof_o on 33; len_o=3; busy_o low afterwards.
REQ-036 Scenario 2: 31 zeros then A7 -> no PHR entry, no outputs, busy_o stays 0.
REQ-037 Scenario 3: 32 zeros, then bits 1,0,0,0,0,0,0,0 (no SFD) -> return to HUNT silently; a following full valid frame is still received.
REQ-038 Scenario 4: valid preamble and SFD, PHR 00 -> frame_err_o pulses once; no byte_valid_o.
REQ-039 Scenario 5: PHR 05, 2 bytes sent, then data_en_i stopped for 4096 cycles -> 2 bytes out, no eof_o, frame_err_o pulse exactly at the timeout, busy_o 0.
REQ-040 Scenario 6: reset_i asserted in PAYLOAD for 1 cycle -> all outputs 0, no frame_err_o; a subsequent frame with PHR 01, payload 5A gives one byte 5A with sof_o=eof_o=1.
